// File: rtl/mem_access_ctrl_if.sv
// Data-memory port bundle between the M-stage access controller and the memory.
// req/we/addr/be/wdata flow to memory; gnt/rvalid/rdata come back.
interface mem_access_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access sequencer: issues req/gnt + rvalid transactions,
// stalls the pipeline until completion and returns extended load data.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_valid,
  input  logic [4:0]          m_op,
  input  logic [2:0]          m_f3,
  input  logic [31:0]         m_addr,
  input  logic [31:0]         m_wdata,
  mem_access_ctrl_if.master   dmem,
  output logic                stall,
  output logic [31:0]         ld_data,
  output logic                ld_valid,
  output logic                misalign_err,
  output logic                bus_err
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       alo_q;

  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        bad_align;
  logic        aligned_op;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] lane;
  logic [31:0] ld_ext;

  assign is_load    = (m_op == OP_LOAD);
  assign is_store   = (m_op == OP_STORE);
  assign mem_op     = m_valid & (is_load | is_store);
  assign aligned_op = mem_op & ~bad_align;

  assign misalign_err = mem_op & bad_align;
  // Reset wins over a held M-stage op so the pipeline is never frozen during reset.
  assign stall        = aligned_op & (state != DONE) & ~rst;

  always_comb begin
    bad_align = 1'b0;
    be_n      = 4'b0000;
    wdata_n   = 32'h0;
    case (m_f3)
      3'b000, 3'b100: begin
        be_n    = 4'b0001 << m_addr[1:0];
        wdata_n = {4{m_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        bad_align = m_addr[0];
        be_n      = 4'b0011 << {m_addr[1], 1'b0};
        wdata_n   = {2{m_wdata[15:0]}};
      end
      3'b010: begin
        bad_align = (m_addr[1:0] != 2'b00);
        be_n      = 4'b1111;
        wdata_n   = m_wdata;
      end
      default: bad_align = 1'b1;
    endcase
  end

  // Load extraction uses the size/offset latched at issue, not the live M-stage fields.
  always_comb begin
    lane   = dmem.rdata >> {alo_q, 3'b000};
    ld_ext = lane;
    case (f3_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'h0, lane[7:0]};
      3'b101:  ld_ext = {16'h0, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= 32'h0;
      dmem.be    <= 4'b0000;
      dmem.wdata <= 32'h0;
      ld_data    <= 32'h0;
      ld_valid   <= 1'b0;
      bus_err    <= 1'b0;
      cnt        <= '0;
      f3_q       <= 3'b000;
      alo_q      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          ld_valid <= 1'b0;
          bus_err  <= 1'b0;
          if (aligned_op) begin
            state      <= REQ;
            dmem.req   <= 1'b1;
            dmem.we    <= is_store;
            dmem.addr  <= {m_addr[31:2], 2'b00};
            dmem.be    <= be_n;
            dmem.wdata <= wdata_n;
            f3_q       <= m_f3;
            alo_q      <= m_addr[1:0];
          end
        end
        REQ: begin
          if (dmem.req && dmem.gnt) begin
            state    <= WAIT;
            dmem.req <= 1'b0;
            cnt      <= '0;
          end
        end
        // A store's rvalid is only a write ack, so load data is left untouched.
        WAIT: begin
          if (dmem.rvalid) begin
            state <= DONE;
            if (!dmem.we) begin
              ld_data  <= ld_ext;
              ld_valid <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            state   <= DONE;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          ld_valid <= 1'b0;
          bus_err  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
